avalon_mm_slave_regs: RTL and testbench

AVALON_MM_SLAVE_REGS -- requirements
Module: avalon_mm_slave_regs

---
 rtl/avalon_mm_slave_regs_if.sv | 37 +++
 rtl/avalon_mm_slave_regs.sv | 139 +++++++++++++
 tb/tb_avalon_mm_slave_regs.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_slave_regs_if.sv
// Avalon-MM bus bundle for avalon_mm_slave_regs.
// With AVALON_MM_SLAVE_RESPONSE_EN defined the bundle also carries RESPONSE.
//
// Handshake: the master raises READ or WRITE and holds ADDRESS, BYTE_ENABLE,
// WRITEDATA and the request stable while WAITREQUEST is high; the transfer
// completes in the single cycle WAITREQUEST is low, and READDATA (and RESPONSE
// when present) are valid in that cycle.
interface avalon_mm_slave_regs_if;
    logic [31:0] ADDRESS;
    logic [3:0]  BYTE_ENABLE;
    logic        READ;
    logic        WRITE;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        WAITREQUEST;
`ifdef AVALON_MM_SLAVE_RESPONSE_EN
    logic [1:0]  RESPONSE;

    modport master (
        output ADDRESS, BYTE_ENABLE, READ, WRITE, WRITEDATA,
        input  READDATA, WAITREQUEST, RESPONSE
    );
    modport slave (
        input  ADDRESS, BYTE_ENABLE, READ, WRITE, WRITEDATA,
        output READDATA, WAITREQUEST, RESPONSE
    );
`else
    modport master (
        output ADDRESS, BYTE_ENABLE, READ, WRITE, WRITEDATA,
        input  READDATA, WAITREQUEST
    );
    modport slave (
        input  ADDRESS, BYTE_ENABLE, READ, WRITE, WRITEDATA,
        output READDATA, WAITREQUEST
    );
`endif
endinterface

// File: rtl/avalon_mm_slave_regs.sv
// avalon_mm_slave_regs: 16 x 32-bit Avalon-MM register file with a fixed
// number of wait states per transfer. Word 0 is a read-only ID register.
// Optional feature macro: AVALON_MM_SLAVE_RESPONSE_EN adds RESPONSE on the
// bus (2'b11 DECODEERROR in ACK for out-of-range addresses, else 2'b00).
//
// Transfer shape: IDLE sees a request -> WAIT for WAIT_CYCLES+1 cycles ->
// ACK for one cycle (WAITREQUEST low) -> IDLE. Dropping the request in WAIT
// aborts with no side effects. Read data is registered on the WAIT->ACK edge;
// writes land on the edge that ends ACK, using what the master drives in ACK.
module avalon_mm_slave_regs #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5A5_0001
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    avalon_mm_slave_regs_if.slave        bus,
    output logic [1:0]                   FSM_STATE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Counter width covers the 0..15 wait-state range.
    localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;

    logic [31:0] regs [0:15];
    logic [31:0] rdata_q;
    logic [31:0] read_word;

    logic        any_req;
    logic        in_range;
    logic [3:0]  word_idx;
    logic        load_rdata;
    logic        do_write;

    // Byte-lane offset bits carry no meaning for a word-wide register file.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^bus.ADDRESS[1:0];

    assign any_req  = bus.READ | bus.WRITE;
    assign in_range = (bus.ADDRESS[31:6] == 26'd0);
    assign word_idx = bus.ADDRESS[5:2];

    // Word 0 is the constant ID; anything outside the 64-byte window reads 0.
    assign read_word = !in_range          ? 32'h0000_0000 :
                       (word_idx == 4'd0) ? ID_VALUE      :
                                            regs[word_idx];

    // State register and wait counter; reset abandons any transfer in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state, wait counter and the strobes that commit reads and writes.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        load_rdata    = 1'b0;
        do_write      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next    = WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (!any_req) begin
                    // Master withdrew the request: drop it without side effects.
                    state_next    = IDLE;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt == 4'd0) begin
                    state_next = ACK;
                    // A simultaneous READ and WRITE is a write; READDATA holds.
                    load_rdata = bus.READ & ~bus.WRITE;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
                // WRITE is re-sampled here; word 0 and out-of-range are dropped.
                do_write   = bus.WRITE & in_range & (word_idx != 4'd0);
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // Register file: byte-masked update on the edge that ends ACK.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.BYTE_ENABLE[b]) begin
                    regs[word_idx][8*b +: 8] <= bus.WRITEDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data register: loads on WAIT->ACK of a read, then holds.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdata_q <= 32'h0000_0000;
        end else if (load_rdata) begin
            rdata_q <= read_word;
        end
    end

    assign bus.READDATA    = rdata_q;
    assign bus.WAITREQUEST = (state != ACK);
    assign FSM_STATE       = state;

`ifdef AVALON_MM_SLAVE_RESPONSE_EN
    // Decode status follows the address presented in ACK; quiet otherwise.
    assign bus.RESPONSE = ((state == ACK) && !in_range) ? 2'b11 : 2'b00;
`endif

endmodule

// File: tb/tb_avalon_mm_slave_regs.sv
// Bench for avalon_mm_slave_regs: a WAIT_CYCLES=2 instance (dut0) and a
// WAIT_CYCLES=0 instance (dut1) against an array-based reference model.
// Define AVALON_MM_SLAVE_RESPONSE_EN to also check RESPONSE.
module tb_avalon_mm_slave_regs;

    localparam int          WC0 = 2;
    localparam int          WC1 = 0;
    localparam logic [31:0] ID  = 32'hA5A5_0001;

    logic       CLK;
    logic       RESET_N;
    logic [1:0] state0;
    logic [1:0] state1;

    avalon_mm_slave_regs_if bus0 ();
    avalon_mm_slave_regs_if bus1 ();

    avalon_mm_slave_regs #(.WAIT_CYCLES(WC0), .ID_VALUE(ID)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus0), .FSM_STATE(state0)
    );
    avalon_mm_slave_regs #(.WAIT_CYCLES(WC1), .ID_VALUE(ID)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus1), .FSM_STATE(state1)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [2][16];
    logic [31:0] last_rd   [2];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] model_read(int sel, logic [31:0] addr);
        logic [3:0] idx;
        idx = addr[5:2];
        if (addr[31:6] != 26'd0) return 32'h0;
        if (idx == 4'd0) return ID;
        return model_mem[sel][idx];
    endfunction

    function automatic void model_write(int sel, logic [31:0] addr, logic [3:0] be,
                                        logic [31:0] data);
        logic [31:0] mask;
        logic [3:0]  idx;
        idx  = addr[5:2];
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (addr[31:6] == 26'd0 && idx != 4'd0)
            model_mem[sel][idx] = (model_mem[sel][idx] & ~mask) | (data & mask);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) model_mem[s][i] = 32'h0;
            last_rd[s] = 32'h0;
        end
    endfunction

    // ---------------- check helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        if (sel == 0) begin
            bus0.READ = rd; bus0.WRITE = wr; bus0.ADDRESS = addr;
            bus0.BYTE_ENABLE = be; bus0.WRITEDATA = data;
        end else begin
            bus1.READ = rd; bus1.WRITE = wr; bus1.ADDRESS = addr;
            bus1.BYTE_ENABLE = be; bus1.WRITEDATA = data;
        end
    endtask

    function automatic logic get_wreq(int sel);
        return (sel == 0) ? bus0.WAITREQUEST : bus1.WAITREQUEST;
    endfunction

    function automatic logic [31:0] get_rdata(int sel);
        return (sel == 0) ? bus0.READDATA : bus1.READDATA;
    endfunction

`ifdef AVALON_MM_SLAVE_RESPONSE_EN
    function automatic logic [1:0] get_resp(int sel);
        return (sel == 0) ? bus0.RESPONSE : bus1.RESPONSE;
    endfunction
`endif

    // One full transfer, started just after a posedge. Cycle 0 is the cycle
    // the request is first presented; ACK must come in cycle WAIT_CYCLES+2.
    task automatic xfer(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data, input bit b2b,
                        output logic [31:0] rdata);
        int          k;
        bit          acked;
        logic [31:0] exp;
        exp = (rd && !wr) ? model_read(sel, addr) : last_rd[sel];
        exp_q.push_back(exp);
        drive(sel, rd, wr, addr, be, data);
        acked = 0;
        rdata = 32'hx;
        for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (!get_wreq(sel)) begin
                acked = 1;
                break;
            end
        end
        exp = exp_q.pop_front();
        if (!acked) begin
            check_int("ack_timeout", k, ((sel == 0) ? WC0 : WC1) + 2);
        end else begin
            check_int("ack_latency", k, ((sel == 0) ? WC0 : WC1) + 2);
            rdata = get_rdata(sel);
            check32("readdata_in_ack", rdata, exp);
`ifdef AVALON_MM_SLAVE_RESPONSE_EN
            check32("response_in_ack", {30'd0, get_resp(sel)},
                    (addr[31:6] != 26'd0) ? 32'd3 : 32'd0);
`endif
        end
        @(posedge CLK);
        #1;
        if (acked) begin
            if (wr) model_write(sel, addr, be, data);
            if (rd && !wr) last_rd[sel] = exp;
        end
        drive(sel, 0, 0, 32'h0, 4'h0, 32'h0);
        if (!b2b && rd && !wr && acked) begin
            @(negedge CLK);
            check32("readdata_hold", get_rdata(sel), last_rd[sel]);
`ifdef AVALON_MM_SLAVE_RESPONSE_EN
            check32("response_idle", {30'd0, get_resp(sel)}, 32'd0);
`endif
            @(posedge CLK);
            #1;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] rd_val;
        bit          abort_ok;
        int          rsel;
        logic [31:0] raddr;

        model_reset();
        drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        drive(1, 0, 0, 32'h0, 4'h0, 32'h0);

        // {rd, wr, addr, be, data, check readdata, expected readdata}
        tbl[0]  = '{0, 1, 32'h08, 4'hF, 32'h1234_5678, 0, 32'h0};
        tbl[1]  = '{1, 0, 32'h08, 4'hF, 32'h0,         1, 32'h1234_5678};
        tbl[2]  = '{0, 1, 32'h04, 4'hF, 32'hFFFF_FFFF, 0, 32'h0};
        tbl[3]  = '{0, 1, 32'h04, 4'h5, 32'h0000_0000, 0, 32'h0};
        tbl[4]  = '{1, 0, 32'h04, 4'hF, 32'h0,         1, 32'hFF00_FF00};
        tbl[5]  = '{0, 1, 32'h00, 4'hF, 32'hDEAD_BEEF, 0, 32'h0};
        tbl[6]  = '{1, 0, 32'h00, 4'hF, 32'h0,         1, 32'hA5A5_0001};
        tbl[7]  = '{0, 1, 32'h40, 4'hF, 32'h7777_7777, 0, 32'h0};
        tbl[8]  = '{1, 0, 32'h40, 4'hF, 32'h0,         1, 32'h0};
        tbl[9]  = '{1, 0, 32'h08, 4'hF, 32'h0,         1, 32'h1234_5678};
        tbl[10] = '{1, 1, 32'h0C, 4'hF, 32'h0000_0055, 1, 32'h1234_5678};
        tbl[11] = '{1, 0, 32'h0C, 4'hF, 32'h0,         1, 32'h0000_0055};

        // ---- reset: asynchronous, outputs quiet while held ----
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        #2;
        check32("reset_waitrequest", {31'd0, bus0.WAITREQUEST}, 32'd1);
        check32("reset_readdata", bus0.READDATA, 32'h0);
        check32("reset_state", {30'd0, state0}, 32'd0);
`ifdef AVALON_MM_SLAVE_RESPONSE_EN
        check32("reset_response", {30'd0, bus0.RESPONSE}, 32'd0);
`endif
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // ---- table-driven directed transfers on dut0 ----
        for (int i = 0; i < 12; i++) begin
            xfer(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].data, 0, rd_val);
            if (tbl[i].chk) check32($sformatf("table_vec%0d", i), rd_val, tbl[i].exp);
        end

        // ---- reset asserted in WAIT: transfer abandoned, readdata cleared ----
        drive(0, 0, 1, 32'h0C, 4'hF, 32'h0000_0001);
        @(negedge CLK);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check32("midreset_waitrequest", {31'd0, bus0.WAITREQUEST}, 32'd1);
        check32("midreset_state", {30'd0, state0}, 32'd0);
        check32("midreset_readdata", bus0.READDATA, 32'h0);
        model_reset();
        drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        xfer(0, 1, 0, 32'h0C, 4'hF, 32'h0, 0, rd_val);
        check32("after_reset_read_0c", rd_val, 32'h0);

        // ---- abort: request dropped in WAIT must never acknowledge ----
        xfer(0, 1, 0, 32'h08, 4'hF, 32'h0, 0, rd_val);
        drive(0, 0, 1, 32'h10, 4'hF, 32'hCAFE_0000);
        @(negedge CLK);
        @(negedge CLK);
        drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
        abort_ok = 1;
        repeat (6) begin
            @(negedge CLK);
            if (!bus0.WAITREQUEST) abort_ok = 0;
        end
        check32("abort_no_ack", {31'd0, abort_ok}, 32'd1);
        check32("abort_readdata_kept", bus0.READDATA, 32'h0);
        @(posedge CLK);
        #1;
        xfer(0, 1, 0, 32'h10, 4'hF, 32'h0, 0, rd_val);

        // ---- randomized transfers on both instances vs model ----
        for (int i = 0; i < 80; i++) begin
            int op;
            int idx;
            rsel = (i % 4 == 3) ? 1 : 0;
            op   = $urandom_range(0, 3);
            idx  = $urandom_range(0, 19);
            if (idx < 16) raddr = 32'(idx) << 2;
            else          raddr = 32'h40 << $urandom_range(0, 25);
            raddr = raddr | 32'($urandom_range(0, 3));
            xfer(rsel, (op == 0 || op == 2 || op == 3), (op == 1 || op == 2), raddr,
                 4'($urandom_range(0, 15)), $urandom, 0, rd_val);
        end

        // ---- WAIT_CYCLES=0: back-to-back reads of 0x4 and 0x8 ----
        xfer(1, 0, 1, 32'h04, 4'hF, 32'hAAAA_0004, 0, rd_val);
        xfer(1, 0, 1, 32'h08, 4'hF, 32'hBBBB_0008, 0, rd_val);
        xfer(1, 1, 0, 32'h04, 4'hF, 32'h0, 1, rd_val);
        check32("b2b_read_04", rd_val, 32'hAAAA_0004);
        xfer(1, 1, 0, 32'h08, 4'hF, 32'h0, 1, rd_val);
        check32("b2b_read_08", rd_val, 32'hBBBB_0008);

        // ---- final report ----
        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
